dmem_responder: RTL

Data-memory responder on the processor's data bus: it is the slave end of the `dadr`/`dmemwd`/`dmemread`/`dmemwrite`/`dmemrd` interface driven by the pipelined MIPS core's MEM stage. It serves a word-indexed RAM and a small memory-mapped I/O window. The window holds a byte-wide transmit FIFO with a valid/ready handshake to an external consumer, a free-running cycle counter and a dropped-write counter. Read data is combinational so the core's single-cycle MEM stage and MEM/WB flop timing are preserved.

---
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Data-bus slave for the MIPS MEM stage: word RAM plus an MMIO
//            window with a byte TX FIFO, cycle counter and drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_BUS_WIDTH  = 32,
    parameter int RAM_ADDR_BITS   = 8,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_BUS_WIDTH-1:0] dadr,
    input  logic [DATA_WIDTH-1:0]     dmemwd,
    input  logic                      dmemread,
    input  logic                      dmemwrite,
    output logic [DATA_WIDTH-1:0]     dmemrd,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready
);

    localparam int c_fifo_depth = 1 << FIFO_DEPTH_LOG2;
    localparam int c_ram_words  = 1 << RAM_ADDR_BITS;

    localparam logic [1:0] c_reg_txdata = 2'd0;
    localparam logic [1:0] c_reg_status = 2'd1;
    localparam logic [1:0] c_reg_cycles = 2'd2;
    localparam logic [1:0] c_reg_drops  = 2'd3;

    logic [DATA_WIDTH-1:0]      r_ram [c_ram_words];
    logic [7:0]                 r_fifo [c_fifo_depth];
    logic [FIFO_DEPTH_LOG2-1:0] r_rdptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_wrptr;
    logic [FIFO_DEPTH_LOG2:0]   r_count;
    logic [31:0]                r_cycles;
    logic [31:0]                r_drops;
    logic                       r_started;

    logic                     w_mmio_sel;
    logic [1:0]               w_reg;
    logic [RAM_ADDR_BITS-1:0] w_ram_idx;
    logic                     w_wr_ram;
    logic                     w_wr_tx;
    logic                     w_wr_cycles;
    logic                     w_wr_drops;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_drop;
    logic [31:0]              w_status;
    logic [31:0]              w_mmio_val;
    logic [DATA_WIDTH-1:0]    w_mmio_rd;
    logic                     w_unused_addr;

    assign w_mmio_sel  = dadr[DATA_BUS_WIDTH-1];
    assign w_reg       = dadr[1:0];
    assign w_ram_idx   = dadr[RAM_ADDR_BITS-1:0];
    // Bits between the RAM index and the window select are don't-care (RAM aliases).
    assign w_unused_addr = ^dadr[DATA_BUS_WIDTH-2:RAM_ADDR_BITS];

    assign w_wr_ram    = dmemwrite & ~w_mmio_sel;
    assign w_wr_tx     = dmemwrite & w_mmio_sel & (w_reg == c_reg_txdata);
    assign w_wr_cycles = dmemwrite & w_mmio_sel & (w_reg == c_reg_cycles);
    assign w_wr_drops  = dmemwrite & w_mmio_sel & (w_reg == c_reg_drops);

    // Count never exceeds depth, so its MSB alone marks a full FIFO.
    assign w_full  = r_count[FIFO_DEPTH_LOG2];
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & tx_ready;
    assign w_push  = w_wr_tx & ~w_full;
    assign w_drop  = w_wr_tx & w_full;

    assign tx_valid = ~w_empty;
    assign tx_data  = r_fifo[r_rdptr];

    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[w_ram_idx] <= dmemwd;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wrptr] <= dmemwd[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdptr <= '0;
            r_wrptr <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_rdptr <= r_rdptr + 1'b1;
            end
            if (w_push) begin
                r_wrptr <= r_wrptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The counter holds through the first edge after release so it reads 0 one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_started <= 1'b0;
            r_cycles  <= '0;
            r_drops   <= '0;
        end else begin
            r_started <= 1'b1;
            if (w_wr_cycles) begin
                r_cycles <= '0;
            end else if (r_started) begin
                r_cycles <= r_cycles + 32'd1;
            end
            if (w_wr_drops) begin
                r_drops <= '0;
            end else if (w_drop && (r_drops != '1)) begin
                r_drops <= r_drops + 32'd1;
            end
        end
    end

    always_comb begin
        w_status = '0;
        w_status[FIFO_DEPTH_LOG2+2:0] = {r_count, w_full, w_empty};
        w_mmio_val = '0;
        case (w_reg)
            c_reg_txdata: w_mmio_val = '0;
            c_reg_status: w_mmio_val = w_status;
            c_reg_cycles: w_mmio_val = r_cycles;
            c_reg_drops:  w_mmio_val = r_drops;
            default:      w_mmio_val = '0;
        endcase
    end

    generate
        if (DATA_WIDTH == 32) begin : g_mmio_exact
            assign w_mmio_rd = w_mmio_val;
        end else if (DATA_WIDTH > 32) begin : g_mmio_zext
            assign w_mmio_rd = {{(DATA_WIDTH-32){1'b0}}, w_mmio_val};
        end else begin : g_mmio_trunc
            assign w_mmio_rd = w_mmio_val[DATA_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        dmemrd = '0;
        if (dmemread) begin
            dmemrd = w_mmio_sel ? w_mmio_rd : r_ram[w_ram_idx];
        end
    end

endmodule
`default_nettype wire
